// File: rtl/dmem_bridge_if.sv
// ============================================================================
// dmem_bridge_if : data-side SRAM-like bus (request / addr_ok / data_ok)
// Revision 1.0
// ============================================================================
`default_nettype none

interface dmem_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

`default_nettype wire

// File: rtl/dmem_bridge.sv
// ============================================================================
// dmem_bridge : MEM-stage to data-bus bridge with stall, hold and flush drain
// Revision 1.0
// ============================================================================
`default_nettype none

module dmem_bridge (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        mem_en,
  input  wire logic        mem_wr,
  input  wire logic [31:0] mem_addr,
  input  wire logic [3:0]  mem_sel,
  input  wire logic [1:0]  mem_size,
  input  wire logic [31:0] mem_wdata,
  input  wire logic        mem_except_flag,
  input  wire logic        flush,
  input  wire logic        pipe_stall,
  dmem_bridge_if.master    bus,
  output logic [31:0]      mem_rdata,
  output logic             dmem_stall
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        cancel_q, cancel_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        start;
  logic        req_c, wr_c, stall_c;
  logic [1:0]  size_c;
  logic [3:0]  wstrb_c;
  logic [31:0] addr_c, wdata_c, rd_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cancel_q <= 1'b0;
      rdata_q  <= 32'h0;
      wr_q     <= 1'b0;
      size_q   <= 2'd0;
      wstrb_q  <= 4'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      rdata_q  <= rdata_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      wstrb_q  <= wstrb_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    start    = mem_en & ~mem_except_flag & ~flush;
    state_d  = state_q;
    cancel_d = cancel_q;
    rdata_d  = rdata_q;
    wr_d     = wr_q;
    size_d   = size_q;
    wstrb_d  = wstrb_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    req_c    = 1'b0;
    wr_c     = wr_q;
    size_c   = size_q;
    wstrb_c  = wstrb_q;
    addr_c   = addr_q;
    wdata_c  = wdata_q;
    stall_c  = 1'b0;
    rd_c     = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // First cycle drives the bus straight from MEM to save a cycle.
          req_c   = 1'b1;
          wr_c    = mem_wr;
          size_c  = mem_size;
          wstrb_c = mem_wr ? mem_sel : 4'h0;
          addr_c  = mem_addr;
          wdata_c = mem_wdata;
          wr_d    = wr_c;
          size_d  = size_c;
          wstrb_d = wstrb_c;
          addr_d  = addr_c;
          wdata_d = wdata_c;
          stall_c = 1'b1;
          state_d = bus.data_addr_ok ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        // The request cannot be withdrawn; a flush only marks it for draining.
        req_c   = 1'b1;
        stall_c = ~cancel_q & ~flush;
        if (flush) cancel_d = 1'b1;
        if (bus.data_addr_ok) state_d = (flush | cancel_q) ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        stall_c = ~bus.data_data_ok & ~flush;
        if (bus.data_data_ok) begin
          rd_c = bus.data_rdata;
          if (!flush) begin
            rdata_d = bus.data_rdata;
            state_d = pipe_stall ? S_HOLD : S_IDLE;
          end else begin
            state_d = S_IDLE;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (~pipe_stall | flush) state_d = S_IDLE;
      end
      S_DRAIN: begin
        stall_c = mem_en;
        if (bus.data_data_ok) begin
          cancel_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.data_req   = ~rst & req_c;
  assign bus.data_wr    = ~rst & wr_c;
  assign bus.data_size  = rst ? 2'd0 : size_c;
  assign bus.data_wstrb = rst ? 4'h0 : wstrb_c;
  assign bus.data_addr  = rst ? 32'h0 : addr_c;
  assign bus.data_wdata = rst ? 32'h0 : wdata_c;
  assign mem_rdata      = rst ? 32'h0 : rd_c;
  assign dmem_stall     = ~rst & stall_c;

endmodule

`default_nettype wire
